// File: rtl/vid_timing_ctrl_if.sv
// vid_timing_ctrl_if: run/busy handshake plus raster strobe, position, sync and blank bundle
interface vid_timing_ctrl_if #(parameter int CNT_W = 9);
    logic run, busy, ce_pix, hs, vs, hb, vb, line_start, frame_start;
    logic [CNT_W-1:0] hcount, vcount;
    modport master (output run, input busy, ce_pix, hcount, vcount, hs, vs, hb, vb, line_start, frame_start);
    modport slave (input run, output busy, ce_pix, hcount, vcount, hs, vs, hb, vb, line_start, frame_start);
endinterface

// File: rtl/vid_timing_ctrl.sv
// vid_timing_ctrl: raster sequencer producing pixel strobe, position, syncs and blanks.
// A stop request is honoured only at the end of a frame so downstream never sees a truncated frame.
module vid_timing_ctrl #(
    parameter int CE_DIV   = 4,
    parameter int CNT_W    = 9,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 272,
    parameter int HS_LEN   = 24,
    parameter int H_TOTAL  = 320,
    parameter int V_ACTIVE = 240,
    parameter int VS_START = 244,
    parameter int VS_LEN   = 3,
    parameter int V_TOTAL  = 262
) (
    input logic clk_vid,
    input logic reset,
    vid_timing_ctrl_if.slave vid
);
    localparam int DW = $clog2(CE_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);
    localparam logic [CNT_W:0] H_LAST = (CNT_W+1)'(H_TOTAL - 1);
    localparam logic [CNT_W:0] V_LAST = (CNT_W+1)'(V_TOTAL - 1);
    localparam logic [CNT_W:0] H_ACT  = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] HS_LO  = (CNT_W+1)'(HS_START);
    localparam logic [CNT_W:0] HS_HI  = (CNT_W+1)'(HS_START + HS_LEN);
    localparam logic [CNT_W:0] V_ACT  = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] VS_LO  = (CNT_W+1)'(VS_START);
    localparam logic [CNT_W:0] VS_HI  = (CNT_W+1)'(VS_START + VS_LEN);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
    logic [1:0] state;
    logic [DW-1:0] div_cnt;
    logic tick, h_last, v_last, stop;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic [CNT_W:0] h_ext, v_ext;
    always_comb begin
        tick = state != IDLE && div_cnt == DIV_LAST;
        h_last = {1'b0, vid.hcount} == H_LAST;
        v_last = {1'b0, vid.vcount} == V_LAST;
        stop = tick && h_last && v_last && state == DRAIN && !vid.run;
        h_nxt = h_last ? '0 : vid.hcount + 1'b1;
        v_nxt = !h_last ? vid.vcount : v_last ? '0 : vid.vcount + 1'b1;
        h_ext = {1'b0, h_nxt};
        v_ext = {1'b0, v_nxt};
    end
    // Decodes are taken from the position being loaded so they line up with ce_pix
    always_ff @(posedge clk_vid) begin
        if (reset || stop) begin
            state <= IDLE;
            div_cnt <= '0;
            vid.busy <= 1'b0;
            vid.ce_pix <= 1'b0;
            vid.hcount <= '0;
            vid.vcount <= '0;
            vid.hs <= 1'b0;
            vid.vs <= 1'b0;
            vid.hb <= 1'b1;
            vid.vb <= 1'b1;
            vid.line_start <= 1'b0;
            vid.frame_start <= 1'b0;
        end else if (state == IDLE) begin
            if (vid.run) begin
                state <= RUN;
                vid.busy <= 1'b1;
                vid.ce_pix <= 1'b1;
                vid.line_start <= 1'b1;
                vid.frame_start <= 1'b1;
                vid.hb <= 1'b0;
                vid.vb <= 1'b0;
            end
        end else begin
            state <= vid.run ? RUN : DRAIN;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            vid.ce_pix <= tick;
            vid.line_start <= tick && h_last;
            vid.frame_start <= tick && h_last && v_last;
            if (tick) begin
                vid.hcount <= h_nxt;
                vid.vcount <= v_nxt;
                vid.hb <= h_ext >= H_ACT;
                vid.hs <= h_ext >= HS_LO && h_ext < HS_HI;
                vid.vb <= v_ext >= V_ACT;
                vid.vs <= v_ext >= VS_LO && v_ext < VS_HI;
            end
        end
    end
endmodule

// File: tb/tb_vid_timing_ctrl.sv
// tb_vid_timing_ctrl: scoreboarded check of the raster sequencer on a tiny raster plus a full-width raster.
module tb_vid_timing_ctrl;
    localparam int CE = 2, HT = 8, HA = 5, HS0 = 6, HSL = 1, VT = 4, VA = 2, VS0 = 3, VSL = 1;
    localparam int VTD = 8;
    typedef logic [25:0] vec_t;
    logic clk_vid = 1'b0;
    logic reset = 1'b1;
    int n_vec = 0, n_err = 0;
    vec_t sb[$];
    vec_t obs;
    bit m_on = 0, m_drain = 0;
    int m_t = 0;

    vid_timing_ctrl_if #(.CNT_W(9)) vif ();
    vid_timing_ctrl_if #(.CNT_W(9)) vdf ();

    vid_timing_ctrl #(.CE_DIV(CE), .CNT_W(9), .H_ACTIVE(HA), .HS_START(HS0), .HS_LEN(HSL), .H_TOTAL(HT),
                      .V_ACTIVE(VA), .VS_START(VS0), .VS_LEN(VSL), .V_TOTAL(VT))
        dut_s (.clk_vid(clk_vid), .reset(reset), .vid(vif));

    // Full horizontal timing and divider; vertical trimmed so two frames stay short
    vid_timing_ctrl #(.V_ACTIVE(5), .VS_START(6), .VS_LEN(2), .V_TOTAL(VTD))
        dut_d (.clk_vid(clk_vid), .reset(reset), .vid(vdf));

    always #5 clk_vid = ~clk_vid;

    assign obs = {vif.busy, vif.ce_pix, vif.hcount, vif.vcount, vif.hs, vif.vs,
                  vif.hb, vif.vb, vif.line_start, vif.frame_start};

    function automatic int m_pix();
        return (m_t / CE) % (HT * VT);
    endfunction

    // Model: elapsed cycles since the start edge determine everything while running
    task automatic model_edge(input bit r, input bit rn);
        vec_t e;
        int pix, h, v;
        bit tk;
        if (r) m_on = 0;
        else if (!m_on) begin
            if (rn) begin m_on = 1; m_drain = 0; m_t = 0; end
        end else begin
            m_t++;
            if (m_drain && !rn && m_t % CE == 0 && m_pix() == 0) m_on = 0;
            else m_drain = !rn;
        end
        if (!m_on) e = {2'b00, 9'd0, 9'd0, 4'b0011, 2'b00};
        else begin
            pix = m_pix();
            h = pix % HT;
            v = pix / HT;
            tk = m_t % CE == 0;
            e = {1'b1, tk, 9'(h), 9'(v), (h >= HS0 && h < HS0 + HSL), (v >= VS0 && v < VS0 + VSL),
                 (h >= HA), (v >= VA), (tk && h == 0), (tk && pix == 0)};
        end
        sb.push_back(e);
    endtask

    task automatic step(input bit r, input bit rn);
        reset = r;
        vif.run = rn;
        model_edge(r, rn);
        @(posedge clk_vid);
        #1;
    endtask

    task automatic test_reset();
        vec_t e;
        for (int i = 0; i < 22; i++) begin
            step(i < 2, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL reset_idle cyc %0d got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_run_held();
        vec_t e;
        int ce_n = 0, ls_n = 0, fs_n = 0;
        for (int i = 0; i < 128; i++) begin
            step(1'b0, 1'b1);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL run_held cyc %0d got %h want %h", i, obs, e); end
            ce_n += int'(vif.ce_pix);
            ls_n += int'(vif.line_start);
            fs_n += int'(vif.frame_start);
        end
        n_vec++;
        if (ce_n !== 64) begin n_err++; $display("FAIL run_held_ce_count got %0d want 64", ce_n); end
        n_vec++;
        if (ls_n !== 8) begin n_err++; $display("FAIL run_held_line_starts got %0d want 8", ls_n); end
        n_vec++;
        if (fs_n !== 2) begin n_err++; $display("FAIL run_held_frame_starts got %0d want 2", fs_n); end
    endtask

    task automatic test_drain();
        vec_t e;
        int ce_n = 0;
        for (int i = 0; i < 200 && !(m_t % CE == 0 && m_pix() == HT + 2); i++) begin
            step(1'b0, 1'b1);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL drain_approach got %h want %h", obs, e); end
        end
        for (int i = 0; i < 200 && m_on; i++) begin
            step(1'b0, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL drain cyc %0d got %h want %h", i, obs, e); end
            ce_n += int'(vif.ce_pix);
        end
        n_vec++;
        if (ce_n !== HT * VT - 1 - (HT + 2)) begin
            n_err++; $display("FAIL drain_ce_count got %0d want %0d", ce_n, HT * VT - 1 - (HT + 2));
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL drain_idle cyc %0d got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_resume();
        vec_t e;
        int last = -1;
        for (int i = 0; i < 65; i++) begin
            step(1'b0, !(i >= 30 && i < 35));
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL resume cyc %0d got %h want %h", i, obs, e); end
            n_vec++;
            if (vif.busy !== 1'b1) begin n_err++; $display("FAIL resume_busy cyc %0d got %b want 1", i, vif.busy); end
            if (vif.ce_pix === 1'b1) begin
                if (last >= 0 && i - last != CE) begin
                    n_err++; $display("FAIL resume_period cyc %0d got %0d want %0d", i, i - last, CE);
                end
                last = i;
            end
        end
        for (int i = 0; i < 200 && m_on; i++) begin
            step(1'b0, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL resume_drain got %h want %h", obs, e); end
        end
    endtask

    task automatic test_reset_mid();
        vec_t e;
        for (int i = 0; i < 200 && !(m_on && m_t % CE == 0 && m_pix() == 2 * HT + 4); i++) begin
            step(1'b0, 1'b1);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL rstmid_approach got %h want %h", obs, e); end
        end
        step(1'b1, 1'b1);
        e = sb.pop_front(); n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL rstmid_idle got %h want %h", obs, e); end
        step(1'b0, 1'b1);
        e = sb.pop_front(); n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL rstmid_restart got %h want %h", obs, e); end
        n_vec++;
        if ({vif.frame_start, vif.hcount, vif.vcount} !== {1'b1, 18'd0}) begin
            n_err++; $display("FAIL rstmid_frame_start got fs=%b h=%0d v=%0d want fs=1 h=0 v=0",
                              vif.frame_start, vif.hcount, vif.vcount);
        end
        for (int i = 0; i < 200 && m_on; i++) begin
            step(1'b0, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL rstmid_drain got %h want %h", obs, e); end
        end
    endtask

    task automatic test_run_pulse();
        vec_t e;
        int ce_n = 0;
        step(1'b0, 1'b1);
        e = sb.pop_front(); n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL pulse_start got %h want %h", obs, e); end
        ce_n += int'(vif.ce_pix);
        for (int i = 0; i < 200 && m_on; i++) begin
            step(1'b0, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL pulse_frame got %h want %h", obs, e); end
            ce_n += int'(vif.ce_pix);
        end
        n_vec++;
        if (ce_n !== HT * VT) begin n_err++; $display("FAIL pulse_ce_count got %0d want %0d", ce_n, HT * VT); end
    endtask

    task automatic test_default();
        int fs_seen = 0, ce_n = 0, hs_n = 0, vs_n = 0, last = -1, bad_per = 0, bad_dec = 0, cyc = 0;
        vdf.run = 1'b1;
        while (fs_seen < 3 && cyc < 30000) begin
            @(posedge clk_vid); #1; cyc++;
            if (vdf.frame_start === 1'b1) fs_seen++;
            if (fs_seen >= 1 && fs_seen < 3 && vdf.ce_pix === 1'b1) begin
                ce_n++;
                hs_n += int'(vdf.hs);
                vs_n += int'(vdf.vs && vdf.line_start);
                if (vdf.hs !== (vdf.hcount >= 272 && vdf.hcount < 296)) bad_dec++;
                if (vdf.hb !== (vdf.hcount >= 256)) bad_dec++;
                if (last >= 0 && cyc - last != 4) bad_per++;
                last = cyc;
            end
        end
        vdf.run = 1'b0;
        n_vec++;
        if (fs_seen !== 3) begin n_err++; $display("FAIL dflt_frames got %0d want 3 (timeout)", fs_seen); end
        n_vec++;
        if (ce_n !== 2 * 320 * VTD) begin n_err++; $display("FAIL dflt_ce_count got %0d want %0d", ce_n, 2 * 320 * VTD); end
        n_vec++;
        if (hs_n !== 2 * VTD * 24) begin n_err++; $display("FAIL dflt_hs_ticks got %0d want %0d", hs_n, 2 * VTD * 24); end
        n_vec++;
        if (vs_n !== 2 * 2) begin n_err++; $display("FAIL dflt_vs_lines got %0d want 4", vs_n); end
        n_vec++;
        if (bad_per !== 0) begin n_err++; $display("FAIL dflt_period got %0d bad intervals want 0", bad_per); end
        n_vec++;
        if (bad_dec !== 0) begin n_err++; $display("FAIL dflt_decode got %0d bad decodes want 0", bad_dec); end
        cyc = 0;
        while (vdf.busy === 1'b1 && cyc < 12000) begin @(posedge clk_vid); #1; cyc++; end
        n_vec++;
        if ({vdf.busy, vdf.hb, vdf.vb, vdf.ce_pix} !== 4'b0110) begin
            n_err++; $display("FAIL dflt_stop got busy/hb/vb/ce=%b want 0110", {vdf.busy, vdf.hb, vdf.vb, vdf.ce_pix});
        end
    endtask

    initial begin
        vif.run = 1'b0;
        vdf.run = 1'b0;
        test_reset();
        test_run_held();
        test_drain();
        test_resume();
        test_reset_mid();
        test_run_pulse();
        test_default();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
